// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing path: standard porch/sync sets,
// a packed colour struct and the line/frame total helper.
package vga_timing_pkg;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
    localparam int VGA640_H_RES  = 640;
    localparam int VGA640_H_FP   = 16;
    localparam int VGA640_H_SYNC = 96;
    localparam int VGA640_H_BP   = 48;
    localparam int VGA640_V_RES  = 480;
    localparam int VGA640_V_FP   = 10;
    localparam int VGA640_V_SYNC = 2;
    localparam int VGA640_V_BP   = 33;

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
    localparam int SVGA800_H_RES  = 800;
    localparam int SVGA800_H_FP   = 40;
    localparam int SVGA800_H_SYNC = 128;
    localparam int SVGA800_H_BP   = 88;
    localparam int SVGA800_V_RES  = 600;
    localparam int SVGA800_V_FP   = 1;
    localparam int SVGA800_V_SYNC = 4;
    localparam int SVGA800_V_BP   = 23;

    // 1280x720 @ 60 Hz, 74.25 MHz pixel clock, positive syncs
    localparam int HD720_H_RES  = 1280;
    localparam int HD720_H_FP   = 110;
    localparam int HD720_H_SYNC = 40;
    localparam int HD720_H_BP   = 220;
    localparam int HD720_V_RES  = 720;
    localparam int HD720_V_FP   = 5;
    localparam int HD720_V_SYNC = 5;
    localparam int HD720_V_BP   = 20;

    // Channel width of the packed colour struct used by pixel producers
    localparam int PKG_CLR_W = 4;

    typedef struct packed {
        logic [PKG_CLR_W-1:0] r;
        logic [PKG_CLR_W-1:0] g;
        logic [PKG_CLR_W-1:0] b;
    } rgb_t;

    // Total pixels per line (or lines per frame) including blanking
    function automatic int calc_total(input int res, input int fp, input int sync, input int bp);
        return res + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Strobe-enabled shift register with a programmable reset value.
// tap is the stage feeding the last register (stage DEPTH-1), dout is the
// final register (stage DEPTH). With DEPTH=1 the tap is the input itself.
module vga_sync_delay #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stb,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    // Shift one stage per strobe; every stage returns to the idle value on reset
    always_ff @(posedge clk) begin
        // NOTE: every stage is reset (not just the output) so no stale sync
        // or enable can reach the pins after a mid-frame reset.
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else if (stb) begin
            // NOTE: non-blocking assignments make each stage take the old
            // value of its predecessor, independent of statement order.
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    generate
        if (DEPTH == 1) begin : g_tap_direct
            assign tap = din;
        end else begin : g_tap_stage
            assign tap = stage[DEPTH-2];
        end
    endgenerate

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_pipe.sv
// Parametrised VGA raster timing with a matched pipeline delay.
// Stage 0 (o_sx/o_sy/o_fetch_de/o_line/o_frame) is issued to the renderer;
// syncs, enable and masked colour appear PIPE_DEPTH strobes later.
// Optional: define VGA_TEST_PATTERN_EN to build the 8-bar test pattern
// selected by i_test; otherwise i_test is ignored.
module vga_timing_pipe
    import vga_timing_pkg::*;
#(
    parameter int H_RES      = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_RES      = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_POL      = 1'b0,
    parameter bit V_POL      = 1'b0,
    parameter int PIPE_DEPTH = 2,
    parameter int COORD_W    = 12,
    parameter int FCNT_W     = 16,
    parameter int CLR_W      = 4
) (
    input  logic               i_pix_clk,
    input  logic               i_rst,
    input  logic               i_pix_stb,
    input  logic [CLR_W-1:0]   i_red,
    input  logic [CLR_W-1:0]   i_green,
    input  logic [CLR_W-1:0]   i_blue,
    input  logic               i_test,
    output logic [COORD_W-1:0] o_sx,
    output logic [COORD_W-1:0] o_sy,
    output logic               o_fetch_de,
    output logic               o_line,
    output logic               o_frame,
    output logic [FCNT_W-1:0]  o_frame_cnt,
    output logic               o_hs,
    output logic               o_vs,
    output logic               o_de,
    output logic [CLR_W-1:0]   o_vga_r,
    output logic [CLR_W-1:0]   o_vga_g,
    output logic [CLR_W-1:0]   o_vga_b
);

    localparam int H_TOTAL = calc_total(H_RES, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_RES, V_FP, V_SYNC, V_BP);

    generate
        if (PIPE_DEPTH < 1 || PIPE_DEPTH > 8) begin : g_bad_pipe_depth
            $error("vga_timing_pipe: PIPE_DEPTH must be in 1..8");
        end
        if (longint'(H_TOTAL) >= (longint'(1) << COORD_W)) begin : g_bad_h_total
            $error("vga_timing_pipe: H_TOTAL does not fit in COORD_W bits");
        end
        if (longint'(V_TOTAL) >= (longint'(1) << COORD_W)) begin : g_bad_v_total
            $error("vga_timing_pipe: V_TOTAL does not fit in COORD_W bits");
        end
    endgenerate

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_RES);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_RES);
    localparam logic [COORD_W-1:0] HS_START = COORD_W'(H_RES + H_FP);
    localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_RES + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] VS_START = COORD_W'(V_RES + V_FP);
    localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_RES + V_FP + V_SYNC);

`ifdef VGA_TEST_PATTERN_EN
    localparam int DW     = 3 + COORD_W;
    localparam int DE_BIT = COORD_W;
    localparam logic [DW-1:0] DLY_RST = {~H_POL, ~V_POL, 1'b0, {COORD_W{1'b0}}};
`else
    localparam int DW     = 3;
    localparam int DE_BIT = 0;
    localparam logic [DW-1:0] DLY_RST = {~H_POL, ~V_POL, 1'b0};
`endif

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               hs_raw;
    logic               vs_raw;
    logic [DW-1:0]      dly_in;
    logic [DW-1:0]      dly_tap;
    logic [DW-1:0]      dly_out;
    logic               de_tap;
    logic [CLR_W-1:0]   src_r;
    logic [CLR_W-1:0]   src_g;
    logic [CLR_W-1:0]   src_b;
    logic [1:0]         unused_tap_sync;

    // Raster counters and completed-frame count; reset wins over the strobe
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            o_frame_cnt <= '0;
        end else if (i_pix_stb) begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                if (v_cnt == V_LAST) begin
                    v_cnt       <= '0;
                    o_frame_cnt <= o_frame_cnt + FCNT_W'(1);
                end else begin
                    v_cnt <= v_cnt + COORD_W'(1);
                end
            end else begin
                h_cnt <= h_cnt + COORD_W'(1);
            end
        end
    end

    assign o_sx       = h_cnt;
    assign o_sy       = v_cnt;
    assign o_fetch_de = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign o_line     = (h_cnt == '0);
    assign o_frame    = (h_cnt == '0) && (v_cnt == '0);
    assign hs_raw     = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? H_POL : ~H_POL;
    assign vs_raw     = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? V_POL : ~V_POL;

`ifdef VGA_TEST_PATTERN_EN
    logic [COORD_W-1:0] h_tap;
    logic [2:0]         bar;
    logic [COORD_W-1:0] unused_out_h;

    assign dly_in       = {hs_raw, vs_raw, o_fetch_de, h_cnt};
    assign h_tap        = dly_tap[COORD_W-1:0];
    assign unused_out_h = dly_out[COORD_W-1:0];
    assign bar          = 3'((32'(h_tap) * 32'd8) / 32'(H_RES));
`else
    logic unused_test;

    assign dly_in      = {hs_raw, vs_raw, o_fetch_de};
    assign unused_test = i_test;
`endif

    vga_sync_delay #(
        .WIDTH   (DW),
        .DEPTH   (PIPE_DEPTH),
        .RST_VAL (DLY_RST)
    ) u_delay (
        .clk  (i_pix_clk),
        .rst  (i_rst),
        .stb  (i_pix_stb),
        .din  (dly_in),
        .tap  (dly_tap),
        .dout (dly_out)
    );

    assign de_tap          = dly_tap[DE_BIT];
    assign unused_tap_sync = dly_tap[DE_BIT+2:DE_BIT+1];
    assign o_de            = dly_out[DE_BIT];
    assign o_vs            = dly_out[DE_BIT+1];
    assign o_hs            = dly_out[DE_BIT+2];

    // Colour source: renderer input, or the bar pattern when built and requested
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        src_r = i_red;
        src_g = i_green;
        src_b = i_blue;
`ifdef VGA_TEST_PATTERN_EN
        if (i_test) begin
            src_r = {CLR_W{bar[0]}};
            src_g = {CLR_W{bar[1]}};
            src_b = {CLR_W{bar[2]}};
        end
`endif
    end

    // Blanking mask registered alongside the final delay stage
    always_ff @(posedge i_pix_clk) begin
        if (i_rst) begin
            o_vga_r <= '0;
            o_vga_g <= '0;
            o_vga_b <= '0;
        end else if (i_pix_stb) begin
            o_vga_r <= de_tap ? src_r : '0;
            o_vga_g <= de_tap ? src_g : '0;
            o_vga_b <= de_tap ? src_b : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Self-checking bench for vga_timing_pipe on a reduced 14x7 raster.
// A table of expected values at chosen strobe counts after reset is applied
// first, then hand-written sequences cover a full-frame sweep, mid-frame
// reset, sparse strobes and (when VGA_TEST_PATTERN_EN is defined) bars.
module tb_vga_timing_pipe;

    localparam int H_RES = 8, H_FP = 2, H_SYNC = 2, H_BP = 2;
    localparam int V_RES = 4, V_FP = 1, V_SYNC = 1, V_BP = 1;
    localparam int PIPE_DEPTH = 2;
    localparam int COORD_W = 12, FCNT_W = 16, CLR_W = 4;

    logic               i_pix_clk = 1'b0;
    logic               i_rst     = 1'b1;
    logic               i_pix_stb = 1'b1;
    logic [CLR_W-1:0]   i_red     = '0;
    logic [CLR_W-1:0]   i_green   = 4'hA;
    logic [CLR_W-1:0]   i_blue    = 4'h5;
    logic               i_test    = 1'b0;
    logic [COORD_W-1:0] o_sx, o_sy;
    logic               o_fetch_de, o_line, o_frame;
    logic [FCNT_W-1:0]  o_frame_cnt;
    logic               o_hs, o_vs, o_de;
    logic [CLR_W-1:0]   o_vga_r, o_vga_g, o_vga_b;

    vga_timing_pipe #(
        .H_RES(H_RES), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_RES(V_RES), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(1'b0), .V_POL(1'b0), .PIPE_DEPTH(PIPE_DEPTH),
        .COORD_W(COORD_W), .FCNT_W(FCNT_W), .CLR_W(CLR_W)
    ) dut (
        .i_pix_clk(i_pix_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
        .i_red(i_red), .i_green(i_green), .i_blue(i_blue), .i_test(i_test),
        .o_sx(o_sx), .o_sy(o_sy), .o_fetch_de(o_fetch_de), .o_line(o_line),
        .o_frame(o_frame), .o_frame_cnt(o_frame_cnt), .o_hs(o_hs), .o_vs(o_vs),
        .o_de(o_de), .o_vga_r(o_vga_r), .o_vga_g(o_vga_g), .o_vga_b(o_vga_b)
    );

    always #5 i_pix_clk = ~i_pix_clk;

    typedef struct {
        int k;
        int sx, sy;
        int fde, line, frame;
        int hs, vs, de;
        int r, g, b;
        int fcnt;
    } vec_t;

    vec_t vecs [18];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock; renderer model returns the red value for the coordinate
    // issued on the strobe just taken (one strobe of renderer latency).
    task automatic step(input bit stb);
        logic [COORD_W-1:0] cur;
        i_pix_stb = stb;
        cur = o_sx;
        @(posedge i_pix_clk);
        #1;
        if (stb) i_red = cur[3:0];
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step(1'b1);
        step(1'b1);
        i_rst = 1'b0;
    endtask

    initial begin
        int k_now;
        int cnt_de, cnt_hs, cnt_vs, cnt_line, cnt_frame, bad_blank;
        int last_line, bad_ival, rises, last_rise, ival, prev_line, held_bad;
        logic [63:0] snap;

        //         k   sx sy fde ln fr hs vs de  r  g  b fcnt
        vecs[0]  = '{0,   0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{1,   1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{2,   2, 0, 1, 0, 0, 1, 1, 1, 0,10, 5, 0};
        vecs[3]  = '{5,   5, 0, 1, 0, 0, 1, 1, 1, 3,10, 5, 0};
        vecs[4]  = '{9,   9, 0, 0, 0, 0, 1, 1, 1, 7,10, 5, 0};
        vecs[5]  = '{10, 10, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[6]  = '{12, 12, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[7]  = '{13, 13, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        vecs[8]  = '{14,  0, 1, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{16,  2, 1, 1, 0, 0, 1, 1, 1, 0,10, 5, 0};
        vecs[10] = '{70,  0, 5, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[11] = '{72,  2, 5, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{85,  1, 6, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        vecs[13] = '{86,  2, 6, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
        vecs[14] = '{98,  0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 1};
        vecs[15] = '{100, 2, 0, 1, 0, 0, 1, 1, 1, 0,10, 5, 1};
        vecs[16] = '{101, 3, 0, 1, 0, 0, 1, 1, 1, 1,10, 5, 1};
        vecs[17] = '{294, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 3};

        do_reset();
        k_now = 0;

        // Table: advance to each row's strobe count, then compare every output
        for (int i = 0; i < 18; i++) begin
            while (k_now < vecs[i].k) begin
                step(1'b1);
                k_now++;
            end
            check($sformatf("row%0d sx", i),    32'(o_sx),        32'(vecs[i].sx));
            check($sformatf("row%0d sy", i),    32'(o_sy),        32'(vecs[i].sy));
            check($sformatf("row%0d fde", i),   32'(o_fetch_de),  32'(vecs[i].fde));
            check($sformatf("row%0d line", i),  32'(o_line),      32'(vecs[i].line));
            check($sformatf("row%0d frame", i), 32'(o_frame),     32'(vecs[i].frame));
            check($sformatf("row%0d hs", i),    32'(o_hs),        32'(vecs[i].hs));
            check($sformatf("row%0d vs", i),    32'(o_vs),        32'(vecs[i].vs));
            check($sformatf("row%0d de", i),    32'(o_de),        32'(vecs[i].de));
            check($sformatf("row%0d r", i),     32'(o_vga_r),     32'(vecs[i].r));
            check($sformatf("row%0d g", i),     32'(o_vga_g),     32'(vecs[i].g));
            check($sformatf("row%0d b", i),     32'(o_vga_b),     32'(vecs[i].b));
            check($sformatf("row%0d fcnt", i),  32'(o_frame_cnt), 32'(vecs[i].fcnt));
        end

        // Full-frame sweep: per-frame counts and 14-clock line spacing
        cnt_de = 0; cnt_hs = 0; cnt_vs = 0; cnt_line = 0; cnt_frame = 0;
        bad_blank = 0; last_line = k_now; bad_ival = 0;
        for (int c = 0; c < 98; c++) begin
            step(1'b1);
            k_now++;
            if (o_de) cnt_de++;
            if (!o_hs) cnt_hs++;
            if (!o_vs) cnt_vs++;
            if (o_frame) cnt_frame++;
            if (!o_de && (o_vga_r != 0 || o_vga_g != 0 || o_vga_b != 0)) bad_blank++;
            if (o_line) begin
                cnt_line++;
                if (k_now - last_line != 14) bad_ival++;
                last_line = k_now;
            end
        end
        check("sweep de clocks", 32'(cnt_de), 32);
        check("sweep hs low clocks", 32'(cnt_hs), 14);
        check("sweep vs low clocks", 32'(cnt_vs), 14);
        check("sweep line pulses", 32'(cnt_line), 7);
        check("sweep frame pulses", 32'(cnt_frame), 1);
        check("sweep line spacing errors", 32'(bad_ival), 0);
        check("sweep colour in blanking", 32'(bad_blank), 0);
        check("sweep fcnt", 32'(o_frame_cnt), 4);

        // Mid-frame reset at h=5, v=2 with the strobe low
        repeat (33) step(1'b1);
        check("pre-rst sx", 32'(o_sx), 5);
        check("pre-rst sy", 32'(o_sy), 2);
        check("pre-rst de", 32'(o_de), 1);
        check("pre-rst r", 32'(o_vga_r), 3);
        i_rst = 1'b1;
        step(1'b0);
        i_rst = 1'b0;
        check("rst sx", 32'(o_sx), 0);
        check("rst sy", 32'(o_sy), 0);
        check("rst hs", 32'(o_hs), 1);
        check("rst vs", 32'(o_vs), 1);
        check("rst de", 32'(o_de), 0);
        check("rst r", 32'(o_vga_r), 0);
        check("rst g", 32'(o_vga_g), 0);
        check("rst fcnt", 32'(o_frame_cnt), 0);
        check("rst frame", 32'(o_frame), 1);
        check("rst line", 32'(o_line), 1);
        check("rst fetch_de", 32'(o_fetch_de), 1);
        step(1'b0);
        check("rst hold sx", 32'(o_sx), 0);
        step(1'b1);
        check("post-rst sx", 32'(o_sx), 1);

        // One strobe in four: line spacing becomes 56 clocks, state frozen between
        do_reset();
        rises = 0; last_rise = -1; ival = 0; held_bad = 0; prev_line = 1;
        for (int c = 0; c < 120; c++) begin
            bit stb;
            stb = (c % 4 == 3);
            snap = {16'(o_sx), 16'(o_sy), o_hs, o_vs, o_de, o_line, o_frame, o_fetch_de,
                    2'b00, o_vga_r, o_vga_g, o_vga_b, o_frame_cnt[3:0]};
            step(stb);
            if (!stb && snap != {16'(o_sx), 16'(o_sy), o_hs, o_vs, o_de, o_line, o_frame,
                                 o_fetch_de, 2'b00, o_vga_r, o_vga_g, o_vga_b,
                                 o_frame_cnt[3:0]}) held_bad++;
            if (o_line && prev_line == 0) begin
                rises++;
                if (last_rise >= 0) ival = c - last_rise;
                last_rise = c;
            end
            prev_line = int'(o_line);
        end
        check("stb4 line rises", 32'(rises), 2);
        check("stb4 line interval", 32'(ival), 56);
        check("stb4 first rise clock", 32'(last_rise - ival), 55);
        check("stb4 held between strobes", 32'(held_bad), 0);

`ifdef VGA_TEST_PATTERN_EN
        // Colour bars: pixel p of line 0 shows bar p
        do_reset();
        i_test = 1'b1;
        step(1'b1);
        for (int p = 0; p < 9; p++) begin
            step(1'b1);
            check($sformatf("bar%0d r", p), 32'(o_vga_r), (p < 8 && p[0]) ? 32'd15 : 32'd0);
            check($sformatf("bar%0d g", p), 32'(o_vga_g), (p < 8 && p[1]) ? 32'd15 : 32'd0);
            check($sformatf("bar%0d b", p), 32'(o_vga_b), (p < 8 && p[2]) ? 32'd15 : 32'd0);
        end
        i_test = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
Parametrised successor to the fixed 640x480 display timing path. Generates raster counters, sync and data-enable, with a configurable pipeline delay that matches the pixel-fetch latency of the renderer and framebuffer. Applies the blanking mask to incoming colour so the sync and pixel outputs are aligned. Sits between the pixel-clock source and the VGA pins; the renderer takes early coordinates from this block and returns colour PIPE_DEPTH-1 cycles later.

Parameters:
H_RES, 640, active pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_RES, 480, active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
PIPE_DEPTH, 2, renderer latency plus one; legal range 1..8
COORD_W, 12, width of coordinate outputs
FCNT_W, 16, width of the frame counter
CLR_W, 4, bits per colour channel

Ports:
i_pix_clk  in  1  pixel clock, the only clock
i_rst  in  1  synchronous reset, active-high
i_pix_stb  in  1  pixel strobe; counters and pipeline advance only when high
i_red/i_green/i_blue  in  CLR_W each  renderer colour for the coordinate issued PIPE_DEPTH-1 strobes earlier
i_test  in  1  test-pattern request (used only with the optional feature)
o_sx, o_sy  out  COORD_W  early (stage-0) raster coordinates, including blanking
o_fetch_de  out  1  stage-0 active-area flag, for addrb generation
o_line  out  1  stage-0 pulse at h==0, every line
o_frame  out  1  stage-0 pulse at h==0, v==0
o_frame_cnt  out  FCNT_W  number of completed frames, wraps
o_hs, o_vs, o_de  out  1  syncs and enable, delayed PIPE_DEPTH strobes
o_vga_r/o_vga_g/o_vga_b  out  CLR_W  masked colour, aligned with o_de

Behaviour:
- H_TOTAL = H_RES+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way. h_cnt runs 0..H_TOTAL-1, then wraps to 0 and increments v_cnt. v_cnt wraps to 0 after V_TOTAL-1.
- Coordinate 0 is the first active pixel. Active area: h<H_RES and v<V_RES.
- Horizontal sync asserted for H_RES+H_FP <= h < H_RES+H_FP+H_SYNC. Vertical sync uses the same rule on v.
- All state changes only on cycles with i_pix_stb=1. When i_pix_stb=0, every register and output holds its value.
- o_sx=h_cnt and o_sy=v_cnt as registers. o_fetch_de, o_line and o_frame are decoded combinationally from those registers.
- o_line and o_frame are high for one strobe each; with i_pix_stb held high, that is one clock.
- o_frame_cnt increments on the strobe where h and v both wrap to 0.
- Stage-0 raw hs/vs/de pass through a PIPE_DEPTH-deep shift register. The output stage is the final register.
- Colour output: o_vga_x <= (de delayed PIPE_DEPTH-1) ? i_x : 0, registered. Colour is therefore zero whenever o_de=0.
- Reset values:
  - h_cnt = v_cnt = 0, o_frame_cnt = 0.
  - Every delay stage holds inactive sync (~H_POL, ~V_POL) with de=0.
  - Colour outputs = 0.
  - o_fetch_de=1, o_line=1, o_frame=1 during and after reset, because they decode h=v=0.
- Reset mid-frame restarts at h=v=0 on the next cycle, regardless of i_pix_stb. No partial sync pulse is extended.
- Elaboration error if PIPE_DEPTH is outside 1..8, or if H_TOTAL or V_TOTAL is at least 2^COORD_W.

Optional Feature:
VGA_TEST_PATTERN_EN.
- Defined: when i_test=1, the colour mux ignores i_red/i_green/i_blue and emits 8 vertical colour bars. Bar index = (h_at_stage PIPE_DEPTH-1 * 8) / H_RES; bit0 drives red, bit1 green, bit2 blue, each at full scale. The h value is carried in the delay line.
- Undefined: i_test is ignored and not connected to logic; the h delay is not built.

Decomposition:
- Package vga_timing_pkg holds:
  - localparam sets for 640x480, 800x600 and 1280x720 porch/sync values;
  - a packed rgb_t struct of CLR_W bits per channel;
  - a function computing totals.
- Sub-module vga_sync_delay: a parametrised shift register with width, depth, reset value and stb enable. It is instantiated once for {hs, vs, de, h}.

Test Plan:
- Small params (H 8/2/2/2 → H_TOTAL=14; V 4/1/1/1 → V_TOTAL=7; PIPE_DEPTH=2; H_POL=V_POL=0), i_pix_stb=1 → o_line every 14 clocks; o_frame every 98 clocks; o_frame_cnt=3 after 294 clocks.
- Same setup → o_hs low exactly at stage-0 h=10,11, seen at the output 2 clocks later; o_vs low for the whole of v=5; o_de high 8 clocks per line on lines 0..3 only.
- Renderer model returns i_red = h[3:0] one clock after o_sx → o_vga_r = 0,1..7 while o_de=1, and 0 in blanking.
- i_pix_stb high one clock in four → every period multiplied by 4 (o_line every 56 clocks); outputs frozen between strobes.
- Assert i_rst at h=5, v=2 for one clock → next cycle h=v=0, o_hs=o_vs=1, o_de=0, colour 0, o_frame_cnt=0; o_frame pulses.
- VGA_TEST_PATTERN_EN defined, i_test=1, H_RES=8 → o_vga_{r,g,b} per pixel 0..7 = bars 000,F00,0F0,FF0,00F,F0F,0FF,FFF.
